// File: rtl/wrap_event_fifo.sv
// Turns each counter wrap (i_en & i_tc) into a sequence-numbered record and queues it
// in a show-ahead FIFO. Overflowing records are dropped, but the sequence number still advances.
module wrap_event_fifo #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_tc,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [SEQ_W-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_overflow,
  input  logic                     i_clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             ovf_q, ovf_d;
  logic [SEQ_W-1:0] mem_q [DEPTH];

  logic empty;
  logic full;
  logic evt;
  logic pop;
  logic push;
  logic drop;

  // The extra pointer MSB separates full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign evt  = i_en & i_tc;
  assign pop  = ~empty & i_ready;
  assign push = evt & (~full | pop);
  assign drop = evt & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    seq_d    = seq_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (evt)  seq_d    = seq_q + SEQ_W'(1);
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop)           ovf_d = 1'b1;
    else if (i_clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible between the reset pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= seq_q;
  end

  assign o_valid    = ~empty;
  assign o_full     = full;
  assign o_level    = wr_ptr_q - rd_ptr_q;
  assign o_overflow = ovf_q;
  assign o_data     = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_wrap_event_fifo.sv
// Bench for wrap_event_fifo: fixed vector table, hand sequences and random traffic
// compared against a queue-based reference model.
module tb_wrap_event_fifo;
  localparam int DEPTH = 4;
  localparam int SEQ_W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, tc = 1'b0, ready = 1'b0, clr = 1'b0;
  logic       o_valid, o_full, o_overflow;
  logic [7:0] o_data;
  logic [2:0] o_level;

  wrap_event_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_tc(tc),
    .o_valid(o_valid), .i_ready(ready), .o_data(o_data),
    .o_level(o_level), .o_full(o_full), .o_overflow(o_overflow),
    .i_clr_ovf(clr)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  // Reference model state
  int mq[$];
  int mseq = 0;
  bit movf = 1'b0;

  typedef struct {
    bit rst_n, en, tc, rdy, clr;
    bit v; int d; int l; bit f; bit o;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit t, input bit rd, input bit c);
    bit evt, pop, full, drop;
    if (!r) begin
      mq.delete();
      mseq = 0;
      movf = 1'b0;
    end else begin
      evt  = e & t;
      pop  = (mq.size() > 0) & rd;
      full = (mq.size() == DEPTH);
      drop = 1'b0;
      if (pop) void'(mq.pop_front());
      if (evt) begin
        if (!full || pop) mq.push_back(mseq);
        else drop = 1'b1;
        mseq = (mseq + 1) % (1 << SEQ_W);
      end
      if (drop) movf = 1'b1;
      else if (c) movf = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("model_valid", int'(o_valid), int'(mq.size() > 0));
    chk("model_level", int'(o_level), mq.size());
    chk("model_full", int'(o_full), int'(mq.size() == DEPTH));
    chk("model_ovf", int'(o_overflow), int'(movf));
    if (mq.size() > 0) chk("model_data", int'(o_data), mq[0]);
  endtask

  task automatic step(input bit r, input bit e, input bit t, input bit rd, input bit c);
    rst_n = r; en = e; tc = t; ready = rd; clr = c;
    @(posedge clk);
    model_step(r, e, t, rd, c);
    #1;
    check_model();
  endtask

  initial begin
    //           rst en tc rdy clr   v  d  l  f  o
    tbl[0]  = '{0, 0, 0, 0, 0,   0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 0,   1, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 0, 1, 0,   0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 1, 0, 0,   1, 1, 1, 0, 0};
    tbl[4]  = '{1, 1, 1, 0, 0,   1, 1, 2, 0, 0};
    tbl[5]  = '{1, 1, 1, 0, 0,   1, 1, 3, 0, 0};
    tbl[6]  = '{1, 1, 1, 0, 0,   1, 1, 4, 1, 0};
    tbl[7]  = '{1, 1, 1, 0, 0,   1, 1, 4, 1, 1};
    tbl[8]  = '{1, 0, 1, 0, 0,   1, 1, 4, 1, 1};
    tbl[9]  = '{1, 1, 1, 1, 0,   1, 2, 4, 1, 1};
    tbl[10] = '{1, 1, 1, 0, 1,   1, 2, 4, 1, 1};
    tbl[11] = '{1, 0, 0, 0, 1,   1, 2, 4, 1, 0};
    tbl[12] = '{1, 0, 0, 1, 0,   1, 3, 3, 0, 0};
    tbl[13] = '{1, 0, 0, 1, 0,   1, 4, 2, 0, 0};
    tbl[14] = '{0, 1, 1, 1, 0,   0, 0, 0, 0, 0};
    tbl[15] = '{1, 1, 1, 1, 0,   1, 0, 1, 0, 0};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst_n, tbl[i].en, tbl[i].tc, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), int'(o_valid), int'(tbl[i].v));
      chk($sformatf("tbl%0d_level", i), int'(o_level), tbl[i].l);
      chk($sformatf("tbl%0d_full", i), int'(o_full), int'(tbl[i].f));
      chk($sformatf("tbl%0d_ovf", i), int'(o_overflow), int'(tbl[i].o));
      if (tbl[i].v) chk($sformatf("tbl%0d_data", i), int'(o_data), tbl[i].d);
    end

    // Reset mid-operation with level 3 and overflow set
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("pre_rst_level", int'(o_level), 3);
    chk("pre_rst_ovf", int'(o_overflow), 1);
    step(0, 1, 1, 0, 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_level", int'(o_level), 0);
    chk("rst_full", int'(o_full), 0);
    chk("rst_ovf", int'(o_overflow), 0);
    chk("rst_data", int'(o_data), 0);
    step(1, 1, 1, 0, 0);
    chk("post_rst_data", int'(o_data), 0);

    // Sequence wrap with continuous pop
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 258; k++) begin
      step(1, 1, 1, 1, 0);
      chk("wrap_data", int'(o_data), k % 256);
      chk("wrap_level", int'(o_level), 1);
      chk("wrap_ovf", int'(o_overflow), 0);
    end

    // Random traffic against the model
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
